// File: rtl/pkg_astro.sv
// Shared constants for the shot-update datapath: board geometry, opcodes, FSM state codes.
package pkg_astro;

  localparam int unsigned N_TIROS = 16;
  localparam int unsigned W_ADDR  = $clog2(N_TIROS);
  localparam int unsigned W_POS   = 4;
  localparam int unsigned W_CNT   = W_ADDR + 1;
  localparam int unsigned W_OP    = 2;
  localparam int unsigned W_EST   = 4;

  localparam logic [W_OP-1:0] OP_CIMA     = 2'b00;
  localparam logic [W_OP-1:0] OP_DIREITA  = 2'b01;
  localparam logic [W_OP-1:0] OP_BAIXO    = 2'b10;
  localparam logic [W_OP-1:0] OP_ESQUERDA = 2'b11;

  typedef enum logic [W_EST-1:0] {
    ST_INICIAL      = 4'h0,
    ST_ESPERA       = 4'h1,
    ST_ZERA         = 4'h2,
    ST_LE           = 4'h3,
    ST_ESCREVE      = 4'h4,
    ST_VERIFICA_FIM = 4'h5,
    ST_INCREMENTA   = 4'h6,
    ST_SINALIZA     = 4'h7,
    ST_ERRO         = 4'hF
  } estado_t;

endpackage

// File: rtl/uc_atualiza_tiros_calcula_movimento.sv
// One-cell move of a shot in its opcode direction, flagging moves that would leave the board.
module calcula_movimento
  import pkg_astro::*;
(
  input  logic [W_POS-1:0] x_i,
  input  logic [W_POS-1:0] y_i,
  input  logic [W_OP-1:0]  opcode_i,
  output logic [W_POS-1:0] novo_x_c,
  output logic [W_POS-1:0] novo_y_c,
  output logic             saiu_tabuleiro_c
);

  localparam logic [W_POS-1:0] POS_MIN = '0;
  localparam logic [W_POS-1:0] POS_MAX = '1;

  // Boundary test comes first so the +/-1 never wraps; on exit the old coordinate is kept.
  always_comb begin
    novo_x_c         = x_i;
    novo_y_c         = y_i;
    saiu_tabuleiro_c = 1'b0;
    case (opcode_i)
      OP_CIMA: begin
        if (y_i == POS_MIN) saiu_tabuleiro_c = 1'b1;
        else                novo_y_c = y_i - W_POS'(1);
      end
      OP_DIREITA: begin
        if (x_i == POS_MAX) saiu_tabuleiro_c = 1'b1;
        else                novo_x_c = x_i + W_POS'(1);
      end
      OP_BAIXO: begin
        if (y_i == POS_MAX) saiu_tabuleiro_c = 1'b1;
        else                novo_y_c = y_i + W_POS'(1);
      end
      default: begin
        if (x_i == POS_MIN) saiu_tabuleiro_c = 1'b1;
        else                novo_x_c = x_i - W_POS'(1);
      end
    endcase
  end

endmodule

// File: rtl/uc_atualiza_tiros.sv
// Sweeps the shot memory on each movement tick, advancing loaded shots and counting survivors.
module uc_atualiza_tiros
  import pkg_astro::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar_atualizacao,
  input  logic              mem_loaded,
  input  logic [W_POS-1:0]  mem_pos_x,
  input  logic [W_POS-1:0]  mem_pos_y,
  input  logic [W_OP-1:0]   mem_opcode,
  output logic [W_ADDR-1:0] mem_endereco,
  output logic              mem_escreve,
  output logic [W_POS-1:0]  mem_novo_x,
  output logic [W_POS-1:0]  mem_novo_y,
  output logic              mem_novo_loaded,
  output logic              ocupado,
  output logic              atualizacao_concluida,
  output logic [W_CNT-1:0]  tiros_ativos,
  output logic [W_EST-1:0]  db_estado_atualiza
);

  estado_t             estado_q, estado_d;
  logic [W_ADDR-1:0]   indice_q;
  logic [W_CNT-1:0]    acum_q;
  logic [W_CNT-1:0]    tiros_q;
  logic                escreve_q;
  logic [W_POS-1:0]    novo_x_q, novo_y_q;
  logic                novo_loaded_q;
  logic                ocupado_q;
  logic                concluida_q;

  logic [W_POS-1:0]    mov_x_c, mov_y_c;
  logic                saiu_c;

  calcula_movimento u_calcula_movimento (
    .x_i              (mem_pos_x),
    .y_i              (mem_pos_y),
    .opcode_i         (mem_opcode),
    .novo_x_c         (mov_x_c),
    .novo_y_c         (mov_y_c),
    .saiu_tabuleiro_c (saiu_c)
  );

  // Next-state decode; unknown encodings fall into erro, which only reset leaves.
  always_comb begin
    estado_d = ST_ERRO;
    case (estado_q)
      ST_INICIAL:      estado_d = ST_ESPERA;
      ST_ESPERA:       estado_d = iniciar_atualizacao ? ST_ZERA : ST_ESPERA;
      ST_ZERA:         estado_d = ST_LE;
      ST_LE:           estado_d = mem_loaded ? ST_ESCREVE : ST_VERIFICA_FIM;
      ST_ESCREVE:      estado_d = ST_VERIFICA_FIM;
      ST_VERIFICA_FIM: estado_d = (indice_q == W_ADDR'(N_TIROS - 1)) ? ST_SINALIZA
                                                                    : ST_INCREMENTA;
      ST_INCREMENTA:   estado_d = ST_LE;
      ST_SINALIZA:     estado_d = ST_ESPERA;
      default:         estado_d = ST_ERRO;
    endcase
  end

  // Outputs are registered from the next state; the write payload is captured in le,
  // where the memory is already addressed at the slot that escreve will update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q      <= ST_INICIAL;
      indice_q      <= '0;
      acum_q        <= '0;
      tiros_q       <= '0;
      escreve_q     <= 1'b0;
      novo_x_q      <= '0;
      novo_y_q      <= '0;
      novo_loaded_q <= 1'b0;
      ocupado_q     <= 1'b0;
      concluida_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;

      case (estado_q)
        ST_ZERA: begin
          indice_q <= '0;
          acum_q   <= '0;
        end
        ST_INCREMENTA: indice_q <= indice_q + W_ADDR'(1);
        ST_ESCREVE:    if (novo_loaded_q) acum_q <= acum_q + W_CNT'(1);
        ST_SINALIZA:   tiros_q <= acum_q;
        default: ;
      endcase

      escreve_q     <= (estado_d == ST_ESCREVE);
      novo_x_q      <= (estado_d == ST_ESCREVE) ? mov_x_c : '0;
      novo_y_q      <= (estado_d == ST_ESCREVE) ? mov_y_c : '0;
      novo_loaded_q <= (estado_d == ST_ESCREVE) && !saiu_c;
      ocupado_q     <= estado_d inside {ST_ZERA, ST_LE, ST_ESCREVE, ST_VERIFICA_FIM,
                                        ST_INCREMENTA, ST_SINALIZA};
      concluida_q   <= (estado_d == ST_SINALIZA);
    end
  end

  assign mem_endereco          = indice_q;
  assign mem_escreve           = escreve_q;
  assign mem_novo_x            = novo_x_q;
  assign mem_novo_y            = novo_y_q;
  assign mem_novo_loaded       = novo_loaded_q;
  assign ocupado               = ocupado_q;
  assign atualizacao_concluida = concluida_q;
  assign tiros_ativos          = tiros_q;
  assign db_estado_atualiza    = W_EST'(estado_q);

endmodule

// File: doc/uc_atualiza_tiros.md
Name: uc_atualiza_tiros

Overview:
Shot-update stage downstream of the special-shot registration unit. It consumes the shot memory that unit fills: (loaded flag, x, y, opcode per slot). On each movement tick it sweeps every slot and advances each loaded shot one cell in its opcode direction. Shots that would leave the board are unloaded, and the number of surviving shots is reported.

Parameters:
N_TIROS, 16, number of shot-memory slots (power of two, ≥2)
W_ADDR, 4, slot address width = log2(N_TIROS)
W_POS, 4, width of each coordinate; board is 2^W_POS × 2^W_POS, coordinates 0..2^W_POS-1

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high; forces state inicial
iniciar_atualizacao  in  1  movement tick; sampled only in espera
mem_loaded  in  1  loaded flag of addressed slot (combinational read)
mem_pos_x  in  W_POS  x of addressed slot
mem_pos_y  in  W_POS  y of addressed slot
mem_opcode  in  2  direction: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1)
mem_endereco  out  W_ADDR  slot index under inspection
mem_escreve  out  1  write enable to shot memory (written on next rising edge)
mem_novo_x  out  W_POS  x to write
mem_novo_y  out  W_POS  y to write
mem_novo_loaded  out  1  loaded flag to write
ocupado  out  1  high in every state except inicial/espera; top level holds off registra_tiro_especial while high
atualizacao_concluida  out  1  one-cycle pulse at end of sweep
tiros_ativos  out  W_ADDR+1  registered count of loaded shots after the last sweep
db_estado_atualiza  out  4  state code for debug

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. On reset: state=inicial, index=0, accumulator=0, tiros_ativos=0. All pulse outputs are 0.
- Moore FSM with these codes: inicial 0, espera 1, zera 2, le 3, escreve 4, verifica_fim 5, incrementa 6, sinaliza 7, erro F. Undefined state goes to erro; erro holds until reset.
- inicial→espera.
- espera: iniciar_atualizacao goes to zera; otherwise stay. Ticks arriving outside espera are dropped and are not queued.
- zera: index←0, accumulator←0 →le.
- le: mem_loaded=1 goes to escreve; otherwise verifica_fim.
- escreve: mem_escreve=1. Compute from mem_opcode:
  - If the move stays in range, write the new coordinate, keep the other coordinate, set novo_loaded=1, and increment the accumulator.
  - Out of range means up with y=0, down with y=max, left with x=0, or right with x=max. In that case write the old coordinate unchanged with novo_loaded=0, and do not increment the accumulator.
  - Then go to verifica_fim.
- verifica_fim: index==N_TIROS-1 goes to sinaliza; otherwise incrementa.
- incrementa: index←index+1 →le.
- sinaliza: atualizacao_concluida=1, tiros_ativos←accumulator →espera.
- Output gating:
  - mem_endereco=index in all states.
  - mem_novo_* are don't-care except in escreve, where they are driven to 0 outside escreve.
  - ocupado=1 in zera..sinaliza.
- Arithmetic: coordinate ±1 is exactly W_POS bits and never wraps; the boundary check precedes the update. The accumulator is W_ADDR+1 bits, so a value of N_TIROS is representable.
- Latency: iniciar sampled in espera at edge t gives the pulse during cycle t+1+3·N_TIROS+L, where L is the number of loaded slots. For N=16: 49 cycles when empty, 65 when full.
- Each slot is written at most once per sweep. A slot whose shot is unloaded is not revisited in the same sweep.
- Reset mid-sweep: the FSM is abandoned immediately and no further writes occur. Slots already written keep their new values. tiros_ativos is cleared to 0.

Decomposition:
- Shared package pkg_astro: opcode constants (OP_CIMA=00, OP_DIREITA=01, OP_BAIXO=10, OP_ESQUERDA=11), W_POS, N_TIROS, and the state encoding.
- One natural sub-module: calcula_movimento. It is combinational; given (x, y, opcode) it returns (novo_x, novo_y, saiu_tabuleiro). The FSM, index counter and accumulator stay in the top module.

Test Plan:
- All slots empty, one tick → no mem_escreve; atualizacao_concluida exactly 49 cycles after the sampling edge; tiros_ativos=0.
- Slot 3 = (x=5, y=5, op 01) loaded → slot 3 becomes (6,5,loaded=1); tiros_ativos=1; pulse at cycle 50.
- Boundary exits: slot 0 (0,7,op 11), slot 1 (15,2,op 01), slot 2 (4,0,op 00), slot 3 (4,15,op 10) → all four written with loaded=0 and coordinates unchanged; tiros_ativos=0.
- All 16 slots loaded at interior positions with mixed opcodes → 16 writes, each with the correct ±1 coordinate; tiros_ativos=16; pulse at cycle 65.
- Second iniciar pulse while ocupado=1 → ignored; exactly one atualizacao_concluida. A tick given after return to espera starts a new sweep.
- Reset asserted during escreve of slot 8 → state inicial immediately; slots 9..15 untouched; tiros_ativos=0; ocupado=0.
